// File: rtl/seven_segment_scan_if.sv
// Pin-side bundle of the seven-segment scanner: shadow-load inputs plus the
// scanned segment/digit outputs and status flags.
interface seven_segment_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_en;
    logic                    load;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame;
    logic                    pending;

    modport master (
        output data_in, dp, blank, lz_en, load,
        input  seg, digit, frame, pending
    );

    modport slave (
        input  data_in, dp, blank, lz_en, load,
        output seg, digit, frame, pending
    );
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex driver for NUM_DIGITS digits on one 7-seg+DP bus, with
// anti-ghost blanking, tear-free frame-synchronous updates and leading-zero blanking.
module seven_segment_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    seven_segment_scan_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INV   = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            4'hF: segs = 7'h71;
            default: segs = 7'h00;
        endcase
        return segs;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are
    // zero; digit 0 and digits showing a decimal point always stay lit.
    function automatic logic lz_blanked(input logic [4*NUM_DIGITS-1:0] data,
                                        input logic [NUM_DIGITS-1:0]   dp,
                                        input logic [IDX_W-1:0]        idx);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx)) && (data[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end else begin
                upper_zero = upper_zero;
            end
        end
        return upper_zero && (idx != {IDX_W{1'b0}}) && !dp[idx];
    endfunction

    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic [4*NUM_DIGITS-1:0] shadow_data_r, shadow_data_nxt_s, active_data_r, active_data_nxt_s;
    logic [NUM_DIGITS-1:0]   shadow_dp_r, shadow_dp_nxt_s, active_dp_r, active_dp_nxt_s;
    logic [NUM_DIGITS-1:0]   shadow_blank_r, shadow_blank_nxt_s, active_blank_r, active_blank_nxt_s;
    logic                    pending_r, pending_nxt_s;
    logic [7:0]              seg_r, seg_raw_s;
    logic [NUM_DIGITS-1:0]   digit_r, digit_raw_s, onehot_s;
    logic                    frame_r;
    logic                    slot_end_s, boundary_s, dark_s;
    logic [3:0]              nib_s;

    // Scan position, shadow/active register transfers and decoded next outputs.
    always_comb begin
        cnt_nxt_s          = cnt_r + CNT_W'(1);
        idx_nxt_s          = idx_r;
        shadow_data_nxt_s  = shadow_data_r;
        shadow_dp_nxt_s    = shadow_dp_r;
        shadow_blank_nxt_s = shadow_blank_r;
        active_data_nxt_s  = active_data_r;
        active_dp_nxt_s    = active_dp_r;
        active_blank_nxt_s = active_blank_r;
        pending_nxt_s      = pending_r;
        onehot_s           = {NUM_DIGITS{1'b0}};
        seg_raw_s          = 8'h00;
        digit_raw_s        = {NUM_DIGITS{1'b0}};

        slot_end_s = (cnt_r == CNT_LAST);
        boundary_s = slot_end_s && (idx_r == IDX_LAST);

        if (slot_end_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end

        if (bus.load) begin
            shadow_data_nxt_s  = bus.data_in;
            shadow_dp_nxt_s    = bus.dp;
            shadow_blank_nxt_s = bus.blank;
        end else begin
            shadow_data_nxt_s  = shadow_data_r;
        end

        // A load landing on the frame boundary bypasses the shadow entirely.
        if (boundary_s && bus.load) begin
            active_data_nxt_s  = bus.data_in;
            active_dp_nxt_s    = bus.dp;
            active_blank_nxt_s = bus.blank;
            pending_nxt_s      = 1'b0;
        end else if (boundary_s && pending_r) begin
            active_data_nxt_s  = shadow_data_r;
            active_dp_nxt_s    = shadow_dp_r;
            active_blank_nxt_s = shadow_blank_r;
            pending_nxt_s      = 1'b0;
        end else if (bus.load) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end

        nib_s           = 4'(active_data_r >> {idx_r, 2'b00});
        onehot_s[idx_r] = 1'b1;
        dark_s = (cnt_r < BLANK_END) || active_blank_r[idx_r]
              || (bus.lz_en && lz_blanked(active_data_r, active_dp_r, idx_r));

        if (dark_s) begin
            seg_raw_s   = 8'h00;
            digit_raw_s = {NUM_DIGITS{1'b0}};
        end else begin
            seg_raw_s   = {active_dp_r[idx_r], decode_hex(nib_s)};
            digit_raw_s = onehot_s;
        end
    end

    // State and registered pin outputs; reset parks every pin in its inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r          <= {CNT_W{1'b0}};
            idx_r          <= {IDX_W{1'b0}};
            shadow_data_r  <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
            shadow_blank_r <= {NUM_DIGITS{1'b0}};
            active_data_r  <= {(4*NUM_DIGITS){1'b0}};
            active_dp_r    <= {NUM_DIGITS{1'b0}};
            active_blank_r <= {NUM_DIGITS{1'b0}};
            pending_r      <= 1'b0;
            seg_r          <= SEG_INV;
            digit_r        <= DIG_INV;
            frame_r        <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt_s;
            idx_r          <= idx_nxt_s;
            shadow_data_r  <= shadow_data_nxt_s;
            shadow_dp_r    <= shadow_dp_nxt_s;
            shadow_blank_r <= shadow_blank_nxt_s;
            active_data_r  <= active_data_nxt_s;
            active_dp_r    <= active_dp_nxt_s;
            active_blank_r <= active_blank_nxt_s;
            pending_r      <= pending_nxt_s;
            seg_r          <= seg_raw_s ^ SEG_INV;
            digit_r        <= digit_raw_s ^ DIG_INV;
            frame_r        <= boundary_s;
        end
    end

    assign bus.seg     = seg_r;
    assign bus.digit   = digit_r;
    assign bus.frame   = frame_r;
    assign bus.pending = pending_r;
endmodule
